// File: rtl/pos_pkg.sv
// ----------------------------------------------------------------------------
// pos_pkg : shared types and defaults for the position update controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pos_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PAYLOAD = 2'd1,
      S_CHECK   = 2'd2,
      S_COMMIT  = 2'd3
   } pos_state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // Field order matches the rendered word: y in [31:16], x in [15:0].
   typedef struct packed {
      logic [15:0] y;
      logic [15:0] x;
   } pos_t;

   function automatic logic [7:0] pos_xor4(input logic [31:0] w);
      return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
   endfunction

endpackage

`default_nettype wire

// File: rtl/pos_clamp.sv
// ----------------------------------------------------------------------------
// pos_clamp : combinational unsigned saturation of one 16-bit coordinate
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pos_clamp #(
   parameter logic [15:0] MAX = 16'hFFFF
) (
   input  logic [15:0] val_i,
   output logic [15:0] val_o
);

   assign val_o = (val_i > MAX) ? MAX : val_i;

endmodule

`default_nettype wire

// File: rtl/pos_update_ctrl.sv
// ----------------------------------------------------------------------------
// pos_update_ctrl : assembles UART position packets, applies them at frame start
// Optional checksum byte enabled by defining POS_CHECKSUM_EN.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pos_update_ctrl
   import pos_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
   parameter logic [15:0] X_MAX          = 16'd440,
   parameter logic [15:0] Y_MAX          = 16'd330,
   parameter logic [15:0] INIT_X         = 16'd0,
   parameter logic [15:0] INIT_Y         = 16'd0
) (
   input  logic        clk_pix,
   input  logic        rst_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        frame_start,
   output logic [31:0] uart_buf,
   output logic        pending,
   output logic        update,
   output logic        pkt_err
);

   localparam logic [21:0] TMO_LAST = 22'(TIMEOUT_CYCLES - 1);

   pos_state_t  state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [21:0] tmo_q, tmo_d;
   logic [31:0] stage_q, stage_d;
   pos_t        pend_q, pend_d;
   pos_t        buf_q, buf_d;
   logic        pending_q, pending_d;
   logic        update_q, update_d;
   logic        err_q, err_d;

   logic [15:0] x_clamped;
   logic [15:0] y_clamped;
   logic        commit;
   logic        apply;
   logic        in_packet;

   pos_clamp #(.MAX(X_MAX)) u_clamp_x (.val_i(stage_q[15:0]),  .val_o(x_clamped));
   pos_clamp #(.MAX(Y_MAX)) u_clamp_y (.val_i(stage_q[31:16]), .val_o(y_clamped));

   assign commit    = (state_q == S_COMMIT);
   assign apply     = frame_start && pending_q;
   assign in_packet = (state_q == S_PAYLOAD) || (state_q == S_CHECK);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      stage_d   = stage_q;
      pend_d    = pend_q;
      buf_d     = buf_q;
      pending_d = pending_q;
      err_d     = 1'b0;
      update_d  = apply;
      tmo_d     = (rx_valid || !in_packet) ? 22'd0 : tmo_q + 22'd1;

      case (state_q)
         // COMMIT behaves like IDLE for byte handling so a back-to-back sync is not lost.
         S_IDLE, S_COMMIT: begin
            state_d = S_IDLE;
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               state_d = S_PAYLOAD;
               idx_d   = 2'd0;
            end
         end
         S_PAYLOAD: begin
            if (rx_valid) begin
               stage_d[{idx_q, 3'b000} +: 8] = rx_data;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
`ifdef POS_CHECKSUM_EN
                  state_d = S_CHECK;
`else
                  state_d = S_COMMIT;
`endif
               end
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
`ifdef POS_CHECKSUM_EN
         S_CHECK: begin
            if (rx_valid) begin
               if (rx_data == pos_xor4(stage_q)) begin
                  state_d = S_COMMIT;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Apply reads the old pending value; a coincident commit re-arms pending.
      if (apply) begin
         buf_d     = pend_q;
         pending_d = 1'b0;
      end
      if (commit) begin
         pend_d    = '{y: y_clamped, x: x_clamped};
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= 2'd0;
         tmo_q     <= 22'd0;
         stage_q   <= 32'd0;
         pend_q    <= '0;
         buf_q     <= '{y: INIT_Y, x: INIT_X};
         pending_q <= 1'b0;
         update_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         tmo_q     <= tmo_d;
         stage_q   <= stage_d;
         pend_q    <= pend_d;
         buf_q     <= buf_d;
         pending_q <= pending_d;
         update_q  <= update_d;
         err_q     <= err_d;
      end
   end

   assign uart_buf = buf_q;
   assign pending  = pending_q;
   assign update   = update_q;
   assign pkt_err  = err_q;

endmodule

`default_nettype wire
